// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: requester handshakes, flush and registered regfile write port of wb_arbiter.
interface wb_arbiter_if #(
   parameter int NAME_W = 5,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4
);
   logic              flush;
   logic              req0_valid, req1_valid, req2_valid;
   logic              req0_ready, req1_ready, req2_ready;
   logic [NAME_W-1:0] req0_name, req1_name, req2_name;
   logic [DATA_W-1:0] req0_data, req1_data, req2_data;
   logic [TAG_W-1:0]  req0_tag, req1_tag, req2_tag;
   logic              en_write;
   logic [NAME_W-1:0] write_name;
   logic [DATA_W-1:0] write_data;
   logic [TAG_W-1:0]  write_tag;
   logic [1:0]        grant_id;
   logic              busy;
   modport slave (
      input  flush,
      input  req0_valid, req1_valid, req2_valid,
      input  req0_name, req1_name, req2_name,
      input  req0_data, req1_data, req2_data,
      input  req0_tag, req1_tag, req2_tag,
      output req0_ready, req1_ready, req2_ready,
      output en_write, write_name, write_data, write_tag, grant_id, busy
   );
   modport master (
      output flush,
      output req0_valid, req1_valid, req2_valid,
      output req0_name, req1_name, req2_name,
      output req0_data, req1_data, req2_data,
      output req0_tag, req1_tag, req2_tag,
      input  req0_ready, req1_ready, req2_ready,
      input  en_write, write_name, write_data, write_tag, grant_id, busy
   );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: three 2-entry result FIFOs arbitrated onto one registered regfile write port.
// WB_ARB_RR_EN selects round-robin arbitration; default is fixed priority 0 > 1 > 2.
module wb_arbiter #(
   parameter int NAME_W = 5,
   parameter int DATA_W = 32,
   parameter int TAG_W  = 4
) (
   input logic        clk,
   input logic        rst,
   wb_arbiter_if.slave bus
);
   localparam int EW = NAME_W + DATA_W + TAG_W;
   logic [2:0]        in_valid, in_ready, push, pop, nonempty;
   logic [EW-1:0]     in_ent [3];
   logic [EW-1:0]     mem_q [3][2];
   logic [EW-1:0]     mem_d [3][2];
   logic [2:0]        wp_q, wp_d, rp_q, rp_d;
   logic [1:0]        cnt_q [3];
   logic [1:0]        cnt_d [3];
   logic              gnt_vld, do_pop;
   logic [1:0]        gnt;
   logic [EW-1:0]     head;
   logic              en_write_q, en_write_d;
   logic [NAME_W-1:0] write_name_q, write_name_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;
   logic [TAG_W-1:0]  write_tag_q, write_tag_d;
   logic [1:0]        grant_id_q, grant_id_d;
   always_comb begin
      in_valid  = {bus.req2_valid, bus.req1_valid, bus.req0_valid};
      in_ent[0] = {bus.req0_name, bus.req0_data, bus.req0_tag};
      in_ent[1] = {bus.req1_name, bus.req1_data, bus.req1_tag};
      in_ent[2] = {bus.req2_name, bus.req2_data, bus.req2_tag};
      for (int r = 0; r < 3; r++) begin
         in_ready[r] = cnt_q[r] < 2'd2;
         nonempty[r] = cnt_q[r] != 2'd0;
      end
   end
`ifdef WB_ARB_RR_EN
   // rr_q is the first requester searched; it moves past the winner on each grant
   logic [1:0] rr_q, rr_d, idx;
   logic [2:0] s;
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = 2'd0;
      s       = '0;
      idx     = '0;
      for (int k = 2; k >= 0; k--) begin
         s   = {1'b0, rr_q} + 3'(k);
         idx = s > 3'd2 ? 2'(s - 3'd3) : 2'(s);
         if (nonempty[idx]) begin
            gnt_vld = 1'b1;
            gnt     = idx;
         end
      end
   end
   assign rr_d = do_pop ? (gnt == 2'd2 ? 2'd0 : gnt + 2'd1) : rr_q;
   always_ff @(posedge clk) rr_q <= rst ? 2'd0 : rr_d;
`else
   assign gnt_vld = |nonempty;
   assign gnt     = nonempty[0] ? 2'd0 : nonempty[1] ? 2'd1 : 2'd2;
`endif
   always_comb begin
      do_pop = gnt_vld && !bus.flush;
      head   = mem_q[gnt][rp_q[gnt]];
      wp_d   = wp_q;
      rp_d   = rp_q;
      mem_d  = mem_q;
      for (int r = 0; r < 3; r++) begin
         push[r]  = in_valid[r] && in_ready[r] && !bus.flush;
         pop[r]   = do_pop && gnt == 2'(r);
         if (push[r]) mem_d[r][wp_q[r]] = in_ent[r];
         wp_d[r]  = bus.flush ? 1'b0 : wp_q[r] ^ push[r];
         rp_d[r]  = bus.flush ? 1'b0 : rp_q[r] ^ pop[r];
         cnt_d[r] = bus.flush ? 2'd0 : cnt_q[r] + {1'b0, push[r]} - {1'b0, pop[r]};
      end
      // a popped x0 head is consumed without writing
      en_write_d   = do_pop && head[EW-1 -: NAME_W] != '0;
      grant_id_d   = do_pop ? gnt : 2'b11;
      write_name_d = en_write_d ? head[EW-1 -: NAME_W] : write_name_q;
      write_data_d = en_write_d ? head[TAG_W +: DATA_W] : write_data_q;
      write_tag_d  = en_write_d ? head[TAG_W-1:0] : write_tag_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q        <= '{default: '0};
         cnt_q        <= '{default: '0};
         wp_q         <= '0;
         rp_q         <= '0;
         en_write_q   <= 1'b0;
         write_name_q <= '0;
         write_data_q <= '0;
         write_tag_q  <= '0;
         grant_id_q   <= 2'b11;
      end else begin
         mem_q        <= mem_d;
         cnt_q        <= cnt_d;
         wp_q         <= wp_d;
         rp_q         <= rp_d;
         en_write_q   <= en_write_d;
         write_name_q <= write_name_d;
         write_data_q <= write_data_d;
         write_tag_q  <= write_tag_d;
         grant_id_q   <= grant_id_d;
      end
   end
   assign bus.req0_ready = in_ready[0];
   assign bus.req1_ready = in_ready[1];
   assign bus.req2_ready = in_ready[2];
   assign bus.en_write   = en_write_q;
   assign bus.write_name = write_name_q;
   assign bus.write_data = write_data_q;
   assign bus.write_tag  = write_tag_q;
   assign bus.grant_id   = grant_id_q;
   assign bus.busy       = |nonempty || en_write_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: table-driven cycle vectors plus directed sequences for wb_arbiter.
module tb_wb_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   wb_arbiter_if #(.NAME_W(5), .DATA_W(32), .TAG_W(4)) bus ();
   wb_arbiter #(.NAME_W(5), .DATA_W(32), .TAG_W(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
   int n_chk = 0;
   int n_fail = 0;
   typedef struct {
      logic       fl;
      logic [2:0] v;
      logic [4:0] n0, n1, n2;
      logic       en;
      logic [1:0] gid;
      logic [4:0] nm;
      logic [2:0] rdy;
      logic       bsy;
   } vec_t;
   vec_t tv [25];
   function automatic vec_t mk(int fl, int v, int n0, int n1, int n2, int en, int gid, int nm, int rdy, int bsy);
      vec_t r;
      r.fl = fl[0]; r.v = 3'(v); r.n0 = 5'(n0); r.n1 = 5'(n1); r.n2 = 5'(n2);
      r.en = en[0]; r.gid = 2'(gid); r.nm = 5'(nm); r.rdy = 3'(rdy); r.bsy = bsy[0];
      return r;
   endfunction
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic drive(logic fl, logic [2:0] v, logic [4:0] n0, logic [4:0] n1, logic [4:0] n2);
      bus.flush      = fl;
      bus.req0_valid = v[0]; bus.req0_name = n0; bus.req0_data = {16'hC0DE, 8'd0, 3'd0, n0}; bus.req0_tag = n0[3:0];
      bus.req1_valid = v[1]; bus.req1_name = n1; bus.req1_data = {16'hC0DE, 8'd1, 3'd0, n1}; bus.req1_tag = n1[3:0];
      bus.req2_valid = v[2]; bus.req2_name = n2; bus.req2_data = {16'hC0DE, 8'd2, 3'd0, n2}; bus.req2_tag = n2[3:0];
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic check_out(string p, logic en, logic [1:0] gid, logic [4:0] nm, logic [2:0] rdy, logic bsy);
      chk({p, ".en_write"}, 32'(bus.en_write), 32'(en));
      chk({p, ".grant_id"}, 32'(bus.grant_id), 32'(gid));
      chk({p, ".write_name"}, 32'(bus.write_name), 32'(nm));
      chk({p, ".ready"}, 32'({bus.req2_ready, bus.req1_ready, bus.req0_ready}), 32'(rdy));
      chk({p, ".busy"}, 32'(bus.busy), 32'(bsy));
      if (en) begin
         chk({p, ".write_data"}, bus.write_data, {16'hC0DE, 6'd0, gid, 3'd0, nm});
         chk({p, ".write_tag"}, 32'(bus.write_tag), 32'(nm[3:0]));
      end
   endtask
   initial begin
      rst = 1'b1;
      drive(1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
      repeat (3) tick;
      check_out("reset", 1'b0, 2'b11, 5'd0, 3'b111, 1'b0);
      chk("reset.write_data", bus.write_data, 32'd0);
      chk("reset.write_tag", 32'(bus.write_tag), 32'd0);
      rst = 1'b0;
`ifdef WB_ARB_RR_EN
      drive(1'b0, 3'b111, 5'd1, 5'd2, 5'd3);
      tick;
      drive(1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         tick;
         check_out($sformatf("rr%0d", i), 1'b1, 2'(i), 5'(i + 1), 3'b111, 1'b1);
      end
      tick;
      check_out("rr_idle", 1'b0, 2'b11, 5'd3, 3'b111, 1'b0);
`else
      tv[0]  = mk(0, 0,  0,  0,  0, 0, 3,  0, 7, 0);
      tv[1]  = mk(0, 1,  3,  0,  0, 0, 3,  0, 7, 1);
      tv[2]  = mk(0, 0,  0,  0,  0, 1, 0,  3, 7, 1);
      tv[3]  = mk(0, 0,  0,  0,  0, 0, 3,  3, 7, 0);
      tv[4]  = mk(0, 7,  1,  2,  3, 0, 3,  3, 7, 1);
      tv[5]  = mk(0, 1,  4,  0,  0, 1, 0,  1, 7, 1);
      tv[6]  = mk(0, 1,  5,  0,  0, 1, 0,  4, 7, 1);
      tv[7]  = mk(0, 0,  0,  0,  0, 1, 0,  5, 7, 1);
      tv[8]  = mk(0, 0,  0,  0,  0, 1, 1,  2, 7, 1);
      tv[9]  = mk(0, 0,  0,  0,  0, 1, 2,  3, 7, 1);
      tv[10] = mk(0, 0,  0,  0,  0, 0, 3,  3, 7, 0);
      tv[11] = mk(0, 3,  6,  7,  0, 0, 3,  3, 7, 1);
      tv[12] = mk(0, 3,  8,  9,  0, 1, 0,  6, 5, 1);
      tv[13] = mk(0, 3, 10, 11,  0, 1, 0,  8, 5, 1);
      tv[14] = mk(0, 0,  0,  0,  0, 1, 0, 10, 5, 1);
      tv[15] = mk(0, 0,  0,  0,  0, 1, 1,  7, 7, 1);
      tv[16] = mk(0, 0,  0,  0,  0, 1, 1,  9, 7, 1);
      tv[17] = mk(0, 0,  0,  0,  0, 0, 3,  9, 7, 0);
      tv[18] = mk(0, 4,  0,  0,  0, 0, 3,  9, 7, 1);
      tv[19] = mk(0, 0,  0,  0,  0, 0, 2,  9, 7, 0);
      tv[20] = mk(0, 0,  0,  0,  0, 0, 3,  9, 7, 0);
      tv[21] = mk(0, 7, 12, 13, 14, 0, 3,  9, 7, 1);
      tv[22] = mk(0, 7, 15, 16, 17, 1, 0, 12, 1, 1);
      tv[23] = mk(1, 1, 18,  0,  0, 0, 3, 12, 7, 0);
      tv[24] = mk(0, 0,  0,  0,  0, 0, 3, 12, 7, 0);
      for (int i = 0; i < 25; i++) begin
         drive(tv[i].fl, tv[i].v, tv[i].n0, tv[i].n1, tv[i].n2);
         tick;
         check_out($sformatf("vec%0d", i), tv[i].en, tv[i].gid, tv[i].nm, tv[i].rdy, tv[i].bsy);
      end
`endif
      drive(1'b0, 3'b001, 5'd3, 5'd0, 5'd0);
      bus.req0_data = 32'hDEADBEEF;
      bus.req0_tag  = 4'd5;
      tick;
      chk("single.no_bypass", 32'(bus.en_write), 32'd0);
      drive(1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
      tick;
      chk("single.en_write", 32'(bus.en_write), 32'd1);
      chk("single.write_name", 32'(bus.write_name), 32'd3);
      chk("single.write_data", bus.write_data, 32'hDEADBEEF);
      chk("single.write_tag", 32'(bus.write_tag), 32'd5);
      chk("single.grant_id", 32'(bus.grant_id), 32'd0);
      drive(1'b0, 3'b111, 5'd1, 5'd2, 5'd3);
      tick;
      drive(1'b0, 3'b110, 5'd0, 5'd4, 5'd5);
      tick;
      chk("pend.en_write", 32'(bus.en_write), 32'd1);
      rst = 1'b1;
      drive(1'b0, 3'b001, 5'd6, 5'd0, 5'd0);
      tick;
      check_out("rst_mid", 1'b0, 2'b11, 5'd0, 3'b111, 1'b0);
      chk("rst_mid.write_data", bus.write_data, 32'd0);
      chk("rst_mid.write_tag", 32'(bus.write_tag), 32'd0);
      rst = 1'b0;
      drive(1'b0, 3'b000, 5'd0, 5'd0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         tick;
         check_out($sformatf("post_rst%0d", i), 1'b0, 2'b11, 5'd0, 3'b111, 1'b0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NAME_W, default 5, register-name width.
REQ-002 SHALL have parameter DATA_W, default 32, write-data width.
REQ-003 SHALL have parameter TAG_W, default 4, reorder tag width.
REQ-004 SHALL have clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have flush  in  1  mispredict flush; discards all pending writes.
REQ-007 SHALL have reqN_valid  in  1  requester N (N=0 ALU, 1 LSU, 2 BRANCH) offers a result.
REQ-008 SHALL have reqN_ready  out  1  requester N's FIFO can accept; combinational from FIFO count only.
REQ-009 SHALL have reqN_name  in  NAME_W  destination register of requester N.
REQ-010 SHALL have reqN_data  in  DATA_W  result value of requester N.
REQ-011 SHALL have reqN_tag  in  TAG_W  reorder tag of requester N.
REQ-012 SHALL have en_write  out  1  registered regfile write enable.
REQ-013 SHALL have write_name  out  NAME_W  registered regfile write name.
REQ-014 SHALL have write_data  out  DATA_W  registered regfile write data.
REQ-015 SHALL have write_tag  out  TAG_W  registered regfile write tag.
REQ-016 SHALL have grant_id  out  2  source requester of the current write; 2'b11 when idle.
REQ-017 SHALL have busy  out  1  any FIFO non-empty or en_write high.

Function
REQ-018 Each requester SHALL own a 2-entry FIFO; push on reqN_valid && reqN_ready; reqN_ready = (count < 2).
REQ-019 Each cycle the arbiter SHALL pop at most one FIFO head total and register it onto the write outputs.
REQ-020 Latency: result pushed in cycle c, uncontended, SHALL show en_write=1 in cycle c+2; no same-cycle bypass.
REQ-021 Same-cycle push and pop on one FIFO SHALL both occur; count unchanged; full FIFO pop frees ready the following cycle only.
REQ-022 Head with name==0 SHALL be popped on grant but en_write SHALL stay 0 that cycle (x0 discarded); grant_id still reports the source.
REQ-023 No non-empty FIFO: en_write=0, grant_id=2'b11; write_name/data/tag hold last values.
REQ-024 flush SHALL empty all FIFOs, drop same-cycle pushes, and force en_write=0, grant_id=2'b11 next cycle; flush has priority over push and grant.
REQ-025 FIFO pointers SHALL wrap modulo 2; count SHALL never exceed 2 nor underflow.

Reset
REQ-026 On rst: FIFOs empty, en_write=0, write_name/data/tag=0, grant_id=2'b11, busy=0, round-robin pointer=0; reqN_ready=1 the cycle after rst deasserts.
REQ-027 rst SHALL override flush and all pushes; rst mid-stream discards pending entries without emitting writes.

Configuration
REQ-028 Macro WB_ARB_RR_EN defined: round-robin; search starts at requester after last granted (wrap 2->0); pointer updates only on a grant.
REQ-029 WB_ARB_RR_EN undefined: fixed priority 0 > 1 > 2; no pointer state.

Verification
REQ-030 Single push req0 name=3 data=0xDEADBEEF tag=5 in cycle 10 -> cycle 12 en_write=1, name=3, data=0xDEADBEEF, tag=5, grant_id=0.
REQ-031 All three push in cycle 10 (names 1,2,3), RR -> grants 0,1,2 in cycles 12,13,14; fixed priority with req0 re-pushing each cycle -> req1/req2 starve while req0 FIFO non-empty.
REQ-032 req1 pushes 3 back-to-back with no grant possible (req0 saturating, fixed priority) -> req1_ready=0 after 2nd push, 3rd held by requester.
REQ-033 Push req2 name=0 -> grant cycle en_write=0, grant_id=2, FIFO drained.
REQ-034 Fill all FIFOs, assert flush one cycle with req0 push -> next cycle en_write=0, busy=0, all ready=1, dropped entry never written.
REQ-035 rst asserted with 4 entries pending -> no en_write afterward, outputs at reset values.
